// File: rtl/mac_result_collector.sv
// mac_result_collector: latches out_sum on each rising edge of done into an
//   in-order FIFO, keeps a capture count, a running checksum and a run FSM.
// Latency: a capture is visible in count/captured/checksum/state one edge after
//   done rises; a read returns rd_data/rd_valid one edge after rd_en.
// Backpressure: none upstream; a capture arriving when full (no read that cycle)
//   or after the run completes is dropped and flagged in sticky overflow.
// Ports: clk/rst (sync, active-high); done/out_sum capture side;
//   rd_en/rd_data/rd_valid read side; count/full/empty occupancy;
//   overflow/captured/all_done/checksum/state run status.
module mac_result_collector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int N     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done,
  input  logic [WIDTH-1:0]         out_sum,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [7:0]               captured,
  output logic                     all_done,
  output logic [15:0]              checksum,
  output logic [1:0]               state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [7:0]       N_C     = 8'(N);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               done_q, done_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         captured_q, captured_d;
  logic               all_done_q, all_done_d;
  logic [15:0]        checksum_q, checksum_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];

  logic cap_ev;
  logic accept;
  logic drop;
  logic rd_fire;

  always_comb begin
    // Edge detect so a held done level produces a single capture.
    cap_ev  = done & ~done_q;
    // empty_q tracks count_q exactly, so it doubles as the "count>0" test.
    rd_fire = rd_en & ~empty_q;
    // When full, a same-cycle read frees the slot the write lands in.
    accept  = cap_ev && (state_q != COMPLETE) && (!full_q || rd_en);
    drop    = cap_ev & ~accept;

    done_d     = done;
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    captured_d = captured_q;
    all_done_d = all_done_q;
    checksum_d = checksum_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    mem_d      = mem_q;

    if (accept) begin
      mem_d[wr_ptr_q] = out_sum;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      if (captured_q != 8'hFF) begin
        captured_d = captured_q + 8'd1;
      end
      checksum_d = checksum_q + 16'(out_sum);
      if (captured_d == N_C) begin
        all_done_d = 1'b1;
      end
    end

    if (rd_fire) begin
      rd_data_d  = mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + 1'b1;
      rd_valid_d = 1'b1;
    end

    case ({accept, rd_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (captured_d == N_C) ? COMPLETE : COLLECT;
        end
      end
      COLLECT: begin
        if (accept && (captured_d == N_C)) begin
          state_d = COMPLETE;
        end
      end
      COMPLETE: state_d = COMPLETE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      captured_q <= 8'd0;
      all_done_q <= 1'b0;
      checksum_q <= 16'd0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      captured_q <= captured_d;
      all_done_q <= all_done_d;
      checksum_q <= checksum_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;
  assign captured = captured_q;
  assign all_done = all_done_q;
  assign checksum = checksum_q;
  assign state    = state_q;

endmodule

// File: tb/tb_mac_result_collector.sv
// Bench for mac_result_collector: two instances share stimulus, one with N=3
// (run completion) and one with N=8 (FIFO full/overflow without completing).
module tb_mac_result_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done = 1'b0;
  logic [7:0] out_sum = 8'h00;
  logic       rd_en = 1'b0;

  logic [7:0]  a_rd_data, b_rd_data;
  logic        a_rd_valid, b_rd_valid;
  logic [2:0]  a_count, b_count;
  logic        a_full, b_full, a_empty, b_empty, a_overflow, b_overflow;
  logic [7:0]  a_captured, b_captured;
  logic        a_all_done, b_all_done;
  logic [15:0] a_checksum, b_checksum;
  logic [1:0]  a_state, b_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_result_collector #(.WIDTH(8), .DEPTH(4), .N(3)) dut_a (
    .clk(clk), .rst(rst), .done(done), .out_sum(out_sum), .rd_en(rd_en),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .count(a_count),
    .full(a_full), .empty(a_empty), .overflow(a_overflow),
    .captured(a_captured), .all_done(a_all_done), .checksum(a_checksum),
    .state(a_state)
  );

  mac_result_collector #(.WIDTH(8), .DEPTH(4), .N(8)) dut_b (
    .clk(clk), .rst(rst), .done(done), .out_sum(out_sum), .rd_en(rd_en),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .count(b_count),
    .full(b_full), .empty(b_empty), .overflow(b_overflow),
    .captured(b_captured), .all_done(b_all_done), .checksum(b_checksum),
    .state(b_state)
  );

  // Inputs set before step() are sampled at its rising edge; outputs are
  // observed 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; done = 1'b0; rd_en = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    out_sum = v; done = 1'b1;
    step();
    done = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; done = 1'b0; rd_en = 1'b0;
    step();
    checks++; if (a_rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", a_rd_data); end
    checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", a_rd_valid); end
    checks++; if (a_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_count); end
    checks++; if (a_full !== 1'b0 || a_empty !== 1'b1) begin failures++; $display("FAIL reset_flags got full=%b empty=%b exp full=0 empty=1", a_full, a_empty); end
    checks++; if (a_overflow !== 1'b0 || a_all_done !== 1'b0) begin failures++; $display("FAIL reset_sticky got ovf=%b all_done=%b exp 0 0", a_overflow, a_all_done); end
    checks++; if (a_captured !== 8'd0 || a_checksum !== 16'h0000) begin failures++; $display("FAIL reset_counters got cap=%0d sum=%h exp 0 0000", a_captured, a_checksum); end
    checks++; if (a_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", a_state); end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    logic [7:0] exp_vals [3];
    exp_vals[0] = 8'h0C; exp_vals[1] = 8'h1E; exp_vals[2] = 8'h2A;
    do_reset();
    pulse(8'h0C);
    checks++; if (a_state !== 2'd1 || a_count !== 3'd1) begin failures++; $display("FAIL nominal_first got state=%0d count=%0d exp 1 1", a_state, a_count); end
    pulse(8'h1E);
    checks++; if (a_all_done !== 1'b0) begin failures++; $display("FAIL nominal_early_done got=%b exp=0", a_all_done); end
    pulse(8'h2A);
    checks++; if (a_count !== 3'd3 || a_captured !== 8'd3) begin failures++; $display("FAIL nominal_counts got count=%0d cap=%0d exp 3 3", a_count, a_captured); end
    checks++; if (a_checksum !== 16'h0054) begin failures++; $display("FAIL nominal_checksum got=%h exp=0054", a_checksum); end
    checks++; if (a_all_done !== 1'b1 || a_state !== 2'd2) begin failures++; $display("FAIL nominal_complete got all_done=%b state=%0d exp 1 2", a_all_done, a_state); end
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== exp_vals[i]) begin failures++; $display("FAIL nominal_read%0d got valid=%b data=%h exp 1 %h", i, a_rd_valid, a_rd_data, exp_vals[i]); end
      step();
      checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL nominal_valid_pulse%0d got=%b exp=0", i, a_rd_valid); end
    end
    checks++; if (a_empty !== 1'b1) begin failures++; $display("FAIL nominal_empty got=%b exp=1", a_empty); end
  endtask

  task automatic test_held();
    do_reset();
    out_sum = 8'h55; done = 1'b1;
    repeat (5) step();
    done = 1'b0;
    step();
    checks++; if (a_captured !== 8'd1 || a_count !== 3'd1) begin failures++; $display("FAIL held_counts got cap=%0d count=%0d exp 1 1", a_captured, a_count); end
    checks++; if (a_checksum !== 16'h0055) begin failures++; $display("FAIL held_checksum got=%h exp=0055", a_checksum); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) pulse(8'(i));
    checks++; if (b_full !== 1'b1 || b_overflow !== 1'b0) begin failures++; $display("FAIL ovf_full got full=%b ovf=%b exp 1 0", b_full, b_overflow); end
    pulse(8'h05);
    checks++; if (b_count !== 3'd4 || b_captured !== 8'd4) begin failures++; $display("FAIL ovf_counts got count=%0d cap=%0d exp 4 4", b_count, b_captured); end
    checks++; if (b_overflow !== 1'b1 || b_full !== 1'b1) begin failures++; $display("FAIL ovf_flag got ovf=%b full=%b exp 1 1", b_overflow, b_full); end
    checks++; if (b_checksum !== 16'h000A) begin failures++; $display("FAIL ovf_checksum got=%h exp=000a", b_checksum); end
    for (int i = 1; i <= 4; i++) begin
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 8'(i)) begin failures++; $display("FAIL ovf_read%0d got valid=%b data=%h exp 1 %h", i, b_rd_valid, b_rd_data, 8'(i)); end
      step();
    end
    checks++; if (b_empty !== 1'b1 || b_count !== 3'd0) begin failures++; $display("FAIL ovf_drained got empty=%b count=%0d exp 1 0", b_empty, b_count); end
  endtask

  task automatic test_full_simul();
    logic [7:0] exp_vals [4];
    exp_vals[0] = 8'h02; exp_vals[1] = 8'h03; exp_vals[2] = 8'h04; exp_vals[3] = 8'h09;
    do_reset();
    for (int i = 1; i <= 4; i++) pulse(8'(i));
    out_sum = 8'h09; done = 1'b1; rd_en = 1'b1;
    step();
    done = 1'b0; rd_en = 1'b0;
    checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 8'h01) begin failures++; $display("FAIL fullrw_read got valid=%b data=%h exp 1 01", b_rd_valid, b_rd_data); end
    checks++; if (b_count !== 3'd4 || b_overflow !== 1'b0 || b_captured !== 8'd5) begin failures++; $display("FAIL fullrw_state got count=%0d ovf=%b cap=%0d exp 4 0 5", b_count, b_overflow, b_captured); end
    step();
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== exp_vals[i]) begin failures++; $display("FAIL fullrw_read%0d got valid=%b data=%h exp 1 %h", i, b_rd_valid, b_rd_data, exp_vals[i]); end
      step();
    end
  endtask

  task automatic test_empty_read();
    do_reset();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++; if (b_rd_valid !== 1'b0 || b_rd_data !== 8'h00) begin failures++; $display("FAIL empty_read got valid=%b data=%h exp 0 00", b_rd_valid, b_rd_data); end
    out_sum = 8'h77; done = 1'b1; rd_en = 1'b1;
    step();
    done = 1'b0; rd_en = 1'b0;
    checks++; if (b_count !== 3'd1 || b_rd_valid !== 1'b0 || b_rd_data !== 8'h00) begin failures++; $display("FAIL empty_rw got count=%0d valid=%b data=%h exp 1 0 00", b_count, b_rd_valid, b_rd_data); end
    step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 8'h77) begin failures++; $display("FAIL empty_followup got valid=%b data=%h exp 1 77", b_rd_valid, b_rd_data); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_vals [3];
    exp_vals[0] = 8'hA1; exp_vals[1] = 8'hB2; exp_vals[2] = 8'hC3;
    do_reset();
    for (int i = 0; i < 3; i++) pulse(exp_vals[i]);
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== exp_vals[i]) begin failures++; $display("FAIL b2b_read%0d got valid=%b data=%h exp 1 %h", i, b_rd_valid, b_rd_data, exp_vals[i]); end
    end
    step();
    rd_en = 1'b0;
    checks++; if (b_rd_valid !== 1'b0 || b_rd_data !== 8'hC3) begin failures++; $display("FAIL b2b_past_empty got valid=%b data=%h exp 0 c3", b_rd_valid, b_rd_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse(8'h11);
    pulse(8'h22);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (a_count !== 3'd0 || a_empty !== 1'b1 || a_full !== 1'b0) begin failures++; $display("FAIL midrst_occ got count=%0d empty=%b full=%b exp 0 1 0", a_count, a_empty, a_full); end
    checks++; if (a_captured !== 8'd0 || a_checksum !== 16'h0000 || a_state !== 2'd0) begin failures++; $display("FAIL midrst_status got cap=%0d sum=%h state=%0d exp 0 0000 0", a_captured, a_checksum, a_state); end
    pulse(8'hFF);
    checks++; if (a_captured !== 8'd1 || a_checksum !== 16'h00FF) begin failures++; $display("FAIL midrst_capture got cap=%0d sum=%h exp 1 00ff", a_captured, a_checksum); end
  endtask

  task automatic test_done_at_release();
    rst = 1'b1; rd_en = 1'b0; out_sum = 8'h33; done = 1'b1;
    step();
    rst = 1'b0;
    step();
    done = 1'b0;
    checks++; if (a_captured !== 8'd1 || a_checksum !== 16'h0033) begin failures++; $display("FAIL release_capture got cap=%0d sum=%h exp 1 0033", a_captured, a_checksum); end
    step();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_held();
    test_overflow();
    test_full_simul();
    test_empty_read();
    test_back_to_back();
    test_reset_mid();
    test_done_at_release();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
